// File: rtl/register_file_mp_pkg.sv
// Shared register-file constants and types for decode, register file and writeback.
package riscv_rf_pkg;
  localparam int unsigned ADDRSIZE_DEF = 5;
  localparam int unsigned WORDSIZE_DEF = 32;
  localparam int unsigned NREAD_DEF    = 2;
  localparam int unsigned ZERO_REG     = 0;

  typedef logic [ADDRSIZE_DEF-1:0] reg_addr_t;
  typedef logic [WORDSIZE_DEF-1:0] reg_word_t;
endpackage

// File: rtl/register_file_mp_if.sv
// Register-file bus: writeback port, read ports and issue-time reservation.
interface register_file_mp_if
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned NREAD    = NREAD_DEF
);
  logic                      regwr;
  logic [ADDRSIZE-1:0]       rd;
  logic [WORDSIZE-1:0]       rddata;
  logic [NREAD*ADDRSIZE-1:0] rs;
  logic [NREAD*WORDSIZE-1:0] rsdata;
  logic [NREAD-1:0]          rsbusy;
  logic                      iss_valid;
  logic [ADDRSIZE-1:0]       iss_rd;
  logic                      iss_ready;

  modport master (
    output regwr, rd, rddata, rs, iss_valid, iss_rd,
    input  rsdata, rsbusy, iss_ready
  );

  modport slave (
    input  regwr, rd, rddata, rs, iss_valid, iss_rd,
    output rsdata, rsbusy, iss_ready
  );
endinterface

// File: rtl/register_file_mp_rf_scoreboard.sv
// Pending-write scoreboard: busy bit per register, set at issue, cleared at writeback.
// RF_BYPASS_EN: a same-cycle writeback hides the busy bit it is about to clear.
module rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned NREAD    = NREAD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [ADDRSIZE-1:0]       iss_rd,
  input  logic                      clr_en,
  input  logic [ADDRSIZE-1:0]       clr_addr,
  input  logic [NREAD*ADDRSIZE-1:0] rs,
  output logic [NREAD-1:0]          rs_busy_c,
  output logic                      iss_ready_c
);
  localparam int unsigned DEPTH = 32'(1) << ADDRSIZE;

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic                set_c;
  logic                fwd_iss_c;
  logic [ADDRSIZE-1:0] rs_addr;

`ifdef RF_BYPASS_EN
  assign fwd_iss_c = clr_en && (clr_addr == iss_rd);
`else
  assign fwd_iss_c = 1'b0;
`endif

  assign iss_ready_c = !busy_q[iss_rd] || (iss_rd == ADDRSIZE'(ZERO_REG)) || fwd_iss_c;
  assign set_c       = iss_valid && iss_ready_c && (iss_rd != ADDRSIZE'(ZERO_REG));

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_c)  busy_d[iss_rd]   = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rs_busy_c = '0;
    rs_addr   = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rs_addr      = rs[i*ADDRSIZE +: ADDRSIZE];
      rs_busy_c[i] = busy_q[rs_addr];
`ifdef RF_BYPASS_EN
      if (clr_en && (rs_addr == clr_addr)) rs_busy_c[i] = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port RISC-V integer register file with r0 hardwired to zero and a
// pending-write scoreboard. RF_BYPASS_EN enables write-through forwarding to reads.
module register_file_mp
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
  parameter int unsigned WORDSIZE = WORDSIZE_DEF,
  parameter int unsigned NREAD    = NREAD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 32'(1) << ADDRSIZE;

  logic [WORDSIZE-1:0]       mem_q [DEPTH];
  logic [WORDSIZE-1:0]       mem_d [DEPTH];
  logic                      wr_en_c;
  logic [NREAD*WORDSIZE-1:0] rsdata_c;
  logic [NREAD-1:0]          rsbusy_c;
  logic                      iss_ready_c;
  logic [ADDRSIZE-1:0]       rs_addr;

  assign wr_en_c = bus.regwr && (bus.rd != ADDRSIZE'(ZERO_REG));

  always_comb begin
    mem_d = mem_q;
    if (wr_en_c) mem_d[bus.rd] = bus.rddata;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Asynchronous read muxes; r0 storage never leaves zero.
  always_comb begin
    rsdata_c = '0;
    rs_addr  = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rs_addr = bus.rs[i*ADDRSIZE +: ADDRSIZE];
      rsdata_c[i*WORDSIZE +: WORDSIZE] = mem_q[rs_addr];
`ifdef RF_BYPASS_EN
      if (wr_en_c && (rs_addr == bus.rd)) rsdata_c[i*WORDSIZE +: WORDSIZE] = bus.rddata;
`endif
    end
  end

  rf_scoreboard #(
    .ADDRSIZE (ADDRSIZE),
    .NREAD    (NREAD)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (bus.iss_valid),
    .iss_rd      (bus.iss_rd),
    .clr_en      (wr_en_c),
    .clr_addr    (bus.rd),
    .rs          (bus.rs),
    .rs_busy_c   (rsbusy_c),
    .iss_ready_c (iss_ready_c)
  );

  assign bus.rsdata    = rsdata_c;
  assign bus.rsbusy    = rsbusy_c;
  assign bus.iss_ready = iss_ready_c;
endmodule
